// File: rtl/lab2_proc_mem_responder.sv
// Word-addressed single-port memory target for the lab2 mem_req_4B_t/mem_resp_4B_t
// val/rdy protocol. Memory is accessed when a request is accepted. The response then
// goes through a fixed-latency pipeline and into an in-order queue that is deep enough
// never to overflow.
module lab2_proc_mem_responder #(
  parameter int p_num_words = 256,
  parameter int p_latency   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqstream_val,
  output logic        reqstream_rdy,
  input  logic [76:0] reqstream_msg,
  output logic        respstream_val,
  input  logic        respstream_rdy,
  output logic [46:0] respstream_msg,
  output logic        error
);

  localparam int c_aw = $clog2(p_num_words);
  localparam int c_qd = p_latency + 1;          // queue depth == max outstanding
  localparam int c_ow = $clog2(c_qd + 1);       // counts 0..c_qd
  localparam int c_pw = $clog2(c_qd);

  // Request field decode (type, opaque, addr, len, data from MSB down)
  logic [2:0]      w_type;
  logic [7:0]      w_opaque;
  logic [31:0]     w_addr;
  logic [1:0]      w_len;
  logic [31:0]     w_data;
  logic [c_aw-1:0] w_idx;
  logic            w_unused_addr;

  assign w_type        = reqstream_msg[76:74];
  assign w_opaque      = reqstream_msg[73:66];
  assign w_addr        = reqstream_msg[65:34];
  assign w_len         = reqstream_msg[33:32];
  assign w_data        = reqstream_msg[31:0];
  assign w_idx         = w_addr[c_aw+1:2];
  // Upper address bits are deliberately ignored so addresses wrap around the array.
  assign w_unused_addr = ^w_addr[31:c_aw+2];

  logic [31:0] r_mem [0:p_num_words-1];
  logic        w_req_fire;
  logic        w_resp_fire;
  logic [31:0] w_word;
  logic [31:0] w_lane;
  logic [31:0] w_merge;
  logic [31:0] w_mask;
  logic [4:0]  w_shift;
  logic        w_malformed;
  logic        w_wr_en;
  logic [31:0] w_resp_data;
  logic [46:0] w_resp_new;

  logic [c_ow-1:0] r_out;
  logic [c_ow-1:0] r_q_count;
  logic [c_pw-1:0] r_q_wr;
  logic [c_pw-1:0] r_q_rd;
  logic [46:0]     r_q_mem [0:c_qd-1];
  logic            r_error;
  logic            w_q_push;
  logic [46:0]     w_q_push_msg;

  // Ready depends only on the registered outstanding count.
  assign reqstream_rdy  = (r_out < c_ow'(c_qd));
  assign w_req_fire     = reqstream_val && reqstream_rdy;
  assign respstream_val = (r_q_count != '0);
  assign w_resp_fire    = respstream_val && respstream_rdy;
  assign respstream_msg = r_q_mem[r_q_rd];
  assign error          = r_error;

  // Read the word combinationally so that a latency of 1 still sees read-after-write
  // data. Then select or merge the lanes and flag malformed requests.
  always_comb begin
    w_word      = r_mem[w_idx];
    w_shift     = 5'd0;
    w_mask      = 32'h0;
    w_lane      = 32'h0;
    w_merge     = w_word;
    w_malformed = (w_type > 3'd2);
    case (w_len)
      2'd0: begin
        w_lane  = w_word;
        w_merge = w_data;
      end
      2'd1: begin
        w_shift = {w_addr[1:0], 3'b000};
        w_mask  = 32'h0000_00ff << w_shift;
        w_lane  = (w_word >> w_shift) & 32'h0000_00ff;
        w_merge = (w_word & ~w_mask) | ((w_data & 32'h0000_00ff) << w_shift);
      end
      2'd2: begin
        w_shift = {w_addr[1], 4'b0000};
        w_mask  = 32'h0000_ffff << w_shift;
        w_lane  = (w_word >> w_shift) & 32'h0000_ffff;
        w_merge = (w_word & ~w_mask) | ((w_data & 32'h0000_ffff) << w_shift);
        if (w_addr[0]) w_malformed = 1'b1;
      end
      default: w_malformed = 1'b1;
    endcase
    w_resp_data = (!w_malformed && (w_type == 3'd0)) ? w_lane : 32'h0;
    w_wr_en     = w_req_fire && !w_malformed && ((w_type == 3'd1) || (w_type == 3'd2));
  end

  assign w_resp_new = {w_type, w_opaque, 2'b00, w_len, w_resp_data};

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_idx] <= w_merge;
  end

  // Latency pipeline: the acceptance edge plus (p_latency-1) stages, the last of which
  // writes the queue.
  generate
    if (p_latency == 1) begin : g_direct
      assign w_q_push     = w_req_fire;
      assign w_q_push_msg = w_resp_new;
    end else begin : g_pipe
      for (genvar gi = 0; gi < p_latency - 1; gi++) begin : g_stage
        logic        r_val;
        logic [46:0] r_msg;
        if (gi == 0) begin : g_first
          // First stage captures the response formed at acceptance.
          always_ff @(posedge clk or posedge reset) begin
            if (reset) r_val <= 1'b0;
            else       r_val <= w_req_fire;
          end
          // Payload needs no reset; its valid bit qualifies it.
          always_ff @(posedge clk) begin
            r_msg <= w_resp_new;
          end
        end else begin : g_next
          // Later stages shift the previous stage forward.
          always_ff @(posedge clk or posedge reset) begin
            if (reset) r_val <= 1'b0;
            else       r_val <= g_stage[gi-1].r_val;
          end
          // Payload follows its valid bit.
          always_ff @(posedge clk) begin
            r_msg <= g_stage[gi-1].r_msg;
          end
        end
      end
      assign w_q_push     = g_stage[p_latency-2].r_val;
      assign w_q_push_msg = g_stage[p_latency-2].r_msg;
    end
  endgenerate

  // Queue storage write.
  always_ff @(posedge clk) begin
    if (w_q_push) r_q_mem[r_q_wr] <= w_q_push_msg;
  end

  // Queue pointers and occupancy (the depth need not be a power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_wr    <= '0;
      r_q_rd    <= '0;
      r_q_count <= '0;
    end else begin
      if (w_q_push)    r_q_wr <= (r_q_wr == c_pw'(c_qd - 1)) ? '0 : r_q_wr + 1'b1;
      if (w_resp_fire) r_q_rd <= (r_q_rd == c_pw'(c_qd - 1)) ? '0 : r_q_rd + 1'b1;
      case ({w_q_push, w_resp_fire})
        2'b10:   r_q_count <= r_q_count + 1'b1;
        2'b01:   r_q_count <= r_q_count - 1'b1;
        default: r_q_count <= r_q_count;
      endcase
    end
  end

  // Outstanding count across pipeline and queue, plus the sticky malformed flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_error <= 1'b0;
    end else begin
      case ({w_req_fire, w_resp_fire})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
      if (w_req_fire && w_malformed) r_error <= 1'b1;
    end
  end

  a_no_q_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_q_push && !w_resp_fire && (r_q_count == c_ow'(c_qd))));

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Directed bench for lab2_proc_mem_responder (default parameters: 256 words, latency 2).
module tb_lab2_proc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqstream_val;
  logic        reqstream_rdy;
  logic [76:0] reqstream_msg;
  logic        respstream_val;
  logic        respstream_rdy;
  logic [46:0] respstream_msg;
  logic        error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stalls = 0;
  logic [46:0] got_msg[$];
  int          got_cyc[$];

  lab2_proc_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .reqstream_val  (reqstream_val),
    .reqstream_rdy  (reqstream_rdy),
    .reqstream_msg  (reqstream_msg),
    .respstream_val (respstream_val),
    .respstream_rdy (respstream_rdy),
    .respstream_msg (respstream_msg),
    .error          (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every response transfer 1ns before the edge on which it happens.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (respstream_val === 1'b1 && respstream_rdy === 1'b1) begin
        got_msg.push_back(respstream_msg);
        got_cyc.push_back(cyc);
        $display("resp cyc=%0d msg=%h", cyc, respstream_msg);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [76:0] req(input logic [2:0] t, input logic [7:0] op,
                                      input logic [31:0] a, input logic [1:0] l,
                                      input logic [31:0] d);
    return {t, op, a, l, d};
  endfunction

  function automatic logic [46:0] resp(input logic [2:0] t, input logic [7:0] op,
                                       input logic [1:0] l, input logic [31:0] d);
    return {t, op, 2'b00, l, d};
  endfunction

  // Present one request; returns at the negedge after it was accepted.
  task automatic send(input logic [76:0] m);
    int n;
    n = 0;
    reqstream_val = 1'b1;
    reqstream_msg = m;
    while (!reqstream_rdy && n < 50) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n == 50) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    reqstream_val = 1'b0;
    $display("req  cyc=%0d msg=%h", cyc, m);
  endtask

  task automatic wait_resps(input int n);
    for (int i = 0; i < 100 && got_msg.size() < n; i++) @(negedge clk);
    chk("resp_count", 64'(got_msg.size()), 64'(n));
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h0101_0101 * 32'(i + 1) ^ 32'h8000_0000;
  endfunction

  initial begin
    int acc;
    logic fire_now;
    reset = 1'b1;
    reqstream_val = 1'b0;
    reqstream_msg = '0;
    respstream_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_resp_val", 64'(respstream_val), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_req_rdy", 64'(reqstream_rdy), 64'd1);
    respstream_rdy = 1'b1;

    // Write then read: exact latency check
    @(negedge clk);
    reqstream_val = 1'b1;
    reqstream_msg = req(3'd1, 8'h11, 32'h1000, 2'd0, 32'hdeadbeef);
    @(negedge clk);
    chk("t1_val_t1", 64'(respstream_val), 64'd0);
    reqstream_msg = req(3'd0, 8'h12, 32'h1000, 2'd0, 32'h0);
    @(negedge clk);
    reqstream_val = 1'b0;
    chk("t1_val_t2", 64'(respstream_val), 64'd1);
    chk("t1_wr_resp", 64'(respstream_msg), 64'(resp(3'd1, 8'h11, 2'd0, 32'h0)));
    @(negedge clk);
    chk("t1_val_t3", 64'(respstream_val), 64'd1);
    chk("t1_rd_resp", 64'(respstream_msg), 64'(resp(3'd0, 8'h12, 2'd0, 32'hdeadbeef)));
    @(negedge clk);
    chk("t1_val_t4", 64'(respstream_val), 64'd0);

    // Byte merge and byte read
    got_msg.delete(); got_cyc.delete();
    send(req(3'd1, 8'h21, 32'h1000, 2'd0, 32'h11223344));
    send(req(3'd1, 8'h22, 32'h1003, 2'd1, 32'h000000aa));
    send(req(3'd0, 8'h23, 32'h1000, 2'd0, 32'h0));
    send(req(3'd0, 8'h24, 32'h1001, 2'd1, 32'h0));
    wait_resps(4);
    chk("t2_r0", 64'(got_msg[0]), 64'(resp(3'd1, 8'h21, 2'd0, 32'h0)));
    chk("t2_r1", 64'(got_msg[1]), 64'(resp(3'd1, 8'h22, 2'd1, 32'h0)));
    chk("t2_r2", 64'(got_msg[2]), 64'(resp(3'd0, 8'h23, 2'd0, 32'haa223344)));
    chk("t2_r3", 64'(got_msg[3]), 64'(resp(3'd0, 8'h24, 2'd1, 32'h00000033)));
    chk("t2_error", 64'(error), 64'd0);

    // Fill eight words, then stream eight reads plus one wrapped read back-to-back
    got_msg.delete(); got_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(req(3'd2, 8'(8'h30 + i), 32'(32'h3040 + 4 * i), 2'd0, pat(i)));
    wait_resps(8);
    chk("t3_init_type", 64'(got_msg[7]), 64'(resp(3'd2, 8'h37, 2'd0, 32'h0)));
    got_msg.delete(); got_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++)
      send(req(3'd0, 8'(8'h38 + i), 32'(32'h3040 + 4 * i), 2'd0, 32'h0));
    send(req(3'd0, 8'h40, 32'h3440, 2'd0, 32'h0));
    wait_resps(9);
    chk("t3_stalls", 64'(stalls), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_rd%0d", i), 64'(got_msg[i]), 64'(resp(3'd0, 8'(8'h38 + i), 2'd0, pat(i))));
      chk($sformatf("t3_cyc%0d", i), 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    end
    chk("t3_wrap", 64'(got_msg[8]), 64'(resp(3'd0, 8'h40, 2'd0, pat(0))));

    // Backpressure: only p_latency+1 requests accepted
    respstream_rdy = 1'b0;
    got_msg.delete(); got_cyc.delete();
    acc = 0;
    reqstream_val = 1'b1;
    reqstream_msg = req(3'd0, 8'h50, 32'h3040, 2'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      fire_now = reqstream_rdy;
      @(negedge clk);
      if (fire_now) begin
        acc++;
        reqstream_msg = req(3'd0, 8'(8'h50 + acc), 32'(32'h3040 + 4 * acc), 2'd0, 32'h0);
      end
    end
    reqstream_val = 1'b0;
    chk("t4_accepted", 64'(acc), 64'd3);
    chk("t4_rdy_low", 64'(reqstream_rdy), 64'd0);
    chk("t4_val_held", 64'(respstream_val), 64'd1);
    respstream_rdy = 1'b1;
    @(negedge clk);
    chk("t4_rdy_rise", 64'(reqstream_rdy), 64'd1);
    wait_resps(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_rd%0d", i), 64'(got_msg[i]), 64'(resp(3'd0, 8'(8'h50 + i), 2'd0, pat(i))));
      chk($sformatf("t4_cyc%0d", i), 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    end

    // Halfword reads and malformed requests
    got_msg.delete(); got_cyc.delete();
    send(req(3'd0, 8'h60, 32'h1002, 2'd2, 32'h0));
    chk("t5_err_before", 64'(error), 64'd0);
    send(req(3'd0, 8'h61, 32'h1001, 2'd2, 32'h0));
    chk("t5_err_set", 64'(error), 64'd1);
    send(req(3'd5, 8'h62, 32'h1000, 2'd0, 32'h12345678));
    send(req(3'd0, 8'h63, 32'h1000, 2'd0, 32'h0));
    wait_resps(4);
    chk("t5_half_ok", 64'(got_msg[0]), 64'(resp(3'd0, 8'h60, 2'd2, 32'h0000aa22)));
    chk("t5_half_bad", 64'(got_msg[1]), 64'(resp(3'd0, 8'h61, 2'd2, 32'h0)));
    chk("t5_bad_type", 64'(got_msg[2]), 64'(resp(3'd5, 8'h62, 2'd0, 32'h0)));
    chk("t5_word_rd", 64'(got_msg[3]), 64'(resp(3'd0, 8'h63, 2'd0, 32'haa223344)));
    chk("t5_err_sticky", 64'(error), 64'd1);

    // Reset with responses queued
    got_msg.delete(); got_cyc.delete();
    send(req(3'd1, 8'h70, 32'h2000, 2'd0, 32'hcafef00d));
    wait_resps(1);
    respstream_rdy = 1'b0;
    send(req(3'd0, 8'h71, 32'h2000, 2'd0, 32'h0));
    send(req(3'd0, 8'h72, 32'h3040, 2'd0, 32'h0));
    repeat (3) @(negedge clk);
    chk("t6_queued", 64'(respstream_val), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_val", 64'(respstream_val), 64'd0);
    chk("t6_rst_err", 64'(error), 64'd0);
    chk("t6_rst_rdy", 64'(reqstream_rdy), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    got_msg.delete(); got_cyc.delete();
    respstream_rdy = 1'b1;
    send(req(3'd0, 8'h73, 32'h2000, 2'd0, 32'h0));
    wait_resps(1);
    chk("t6_readback", 64'(got_msg[0]), 64'(resp(3'd0, 8'h73, 2'd0, 32'hcafef00d)));
    repeat (5) @(negedge clk);
    chk("t6_no_stale", 64'(got_msg.size()), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
